// File: rtl/ring_sequencer.sv
// ring_sequencer: NBITS-wide rotate/Johnson/bounce/binary pattern sequencer
// with enable-gated prescaler, parallel load, illegal-state recovery and wrap pulse.
module ring_sequencer #(
    parameter int NBITS = 4,
    parameter int DIV   = 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    output logic [NBITS-1:0] q,
    output logic             wrap,
    output logic             legal
);
    localparam int PW = $clog2(DIV) + 1;
    localparam logic [1:0] ROT    = 2'd0;
    localparam logic [1:0] JOHN   = 2'd1;
    localparam logic [1:0] BOUNCE = 2'd2;
    localparam logic [1:0] BIN    = 2'd3;

    logic [PW-1:0]    pcnt;
    logic             bdir;
    logic             step;
    logic             nbdir;
    logic [NBITS-1:0] start;
    logic [NBITS-1:0] nq;

    // odd modes (Johnson, binary) start from all-zeros, one-hot modes from bit 0
    assign start = mode[0] ? '0 : NBITS'(1);
    assign step  = en && (pcnt == PW'(DIV - 1));

    assign legal = (mode == BIN)  ? 1'b1 :
                   (mode == JOHN) ? ($countones(q[NBITS-1:1] ^ q[NBITS-2:0]) <= 1) :
                                    ($countones(q) == 1);

    // bounce turns around when the lit bit reaches the end it is heading toward
    assign nbdir = (mode == BOUNCE) ? (bdir ? ~q[0] : q[NBITS-1]) : bdir;

    assign nq = (mode == ROT)    ? (dir ? {q[0], q[NBITS-1:1]} : {q[NBITS-2:0], q[NBITS-1]}) :
                (mode == JOHN)   ? (dir ? {~q[0], q[NBITS-1:1]} : {q[NBITS-2:0], ~q[NBITS-1]}) :
                (mode == BOUNCE) ? (nbdir ? q >> 1 : q << 1) :
                                   (dir ? q - 1'b1 : q + 1'b1);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            q    <= start;
            bdir <= 1'b0;
            pcnt <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            bdir <= dir;
            pcnt <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en)
                pcnt <= step ? '0 : pcnt + 1'b1;
            if (step) begin
                q    <= legal ? nq : start;
                bdir <= legal ? nbdir : 1'b0;
                wrap <= legal && (nq == start);
            end
        end
    end
endmodule
